simplez_uart_tx: RTL and testbench
==================================

SIMPLEZ_UART_TX -- requirements
Module: simplez_uart_tx

Interface
REQ-001 Parameter DATAW, default 12: data bus width.
REQ-002 Parameter ADDRW, default 9: address bus width.
REQ-003 Parameter BAUD_DIV, default 104: clk cycles per serial bit; legal range is 2 or more.
REQ-004 Parameter ADDR_DATA, default 9'o506: transmit data register address.
REQ-005 Parameter ADDR_STAT, default 9'o507: status register address.
REQ-006 clk  input  1: single clock; all state updates on the falling edge, matching the Simplez CPU.
REQ-007 rst  input  1: reset, asynchronous, active-high.
REQ-008 addr  input  ADDRW: CPU address register (RA) value.
REQ-009 wr  input  1: CPU write strobe (esc), active-high, one cycle.
REQ-010 data_in  input  DATAW: CPU data bus (busD).
REQ-011 data_out  output  DATAW: read data; combinational from addr and state.
REQ-012 sel  output  1: high when addr equals ADDR_DATA or ADDR_STAT; the CPU-side bus mux uses it.
REQ-013 tx  output  1: serial line, registered, idle high.
REQ-014 busy  output  1: high whenever the state machine is not IDLE.

Function
REQ-015 A write transaction is wr=1 with addr=ADDR_DATA, sampled at a falling edge; data_in[7:0] is the byte and data_in[11:8] is ignored.
REQ-016 State machine: IDLE -> START -> DATA -> STOP -> IDLE, or STOP -> START when a byte is pending (REQ-031).
REQ-017 A write accepted in IDLE latches the byte into the shift register, enters START and drives tx=0, all on that same edge.
REQ-018 Baud counter: runs 0..BAUD_DIV-1 in every non-IDLE state; each state or bit advance occurs when the counter wraps, so every bit lasts exactly BAUD_DIV cycles.
REQ-019 DATA: 8 bits, LSB first; a 3-bit counter goes 0..7, and the exit to STOP happens on the wrap with count 7.
REQ-020 STOP drives tx=1 for BAUD_DIV cycles; the frame is exactly 10*BAUD_DIV cycles from the start edge.
REQ-021 A write to ADDR_DATA while it cannot be accepted (busy, and no free hold slot when the configuration feature is compiled in) drops the byte, sets the sticky overrun flag and leaves the frame in progress unaffected.
REQ-022 A write to ADDR_STAT with data_in[1]=1 clears overrun; other status bits are read-only.
REQ-023 If a clear of overrun and a new overrun occur on the same edge, overrun ends set.
REQ-024 data_out at addr=ADDR_STAT: bit0=ready (a write would be accepted), bit1=overrun, bit2=busy, bits[11:3]=0.
REQ-025 data_out at addr=ADDR_DATA: {4'b0, last accepted byte}.
REQ-026 data_out is all zeros when sel=0.
REQ-027 wr with any other address has no effect.

Reset
REQ-028 Asserting rst immediately, without waiting for a clock edge, forces: state=IDLE, tx=1, busy=0, baud counter=0, bit counter=0, shift register=0, overrun=0, hold register empty.
REQ-029 Reset asserted mid-frame aborts the frame; there is no stop bit or resumption after release.
REQ-030 The first write is accepted on the first falling edge after rst deasserts.

Configuration
REQ-031 Macro SIMPLEZ_UART_HOLD_EN, when defined, adds a one-byte hold register. A write while busy with the hold empty is stored there; ready stays 1 until the hold is full. At the STOP wrap the pending byte moves to the shift register and the block enters START with no idle gap. A write while the hold is full is an overrun.
REQ-032 When SIMPLEZ_UART_HOLD_EN is undefined, there is no hold register: ready equals not busy, and any write while busy is an overrun.

Verification
REQ-033 BAUD_DIV=4, write 12'h055 in IDLE: tx is 0 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; busy is high for exactly 40 cycles.
REQ-034 Without the macro, write 8'hA5, then 8'h3C 5 cycles later: only A5 is transmitted, and a status read returns 12'h006 (overrun=1, busy=1).
REQ-035 With the macro, write 8'hA5, then 8'h3C 5 cycles later: both frames go out back-to-back (tx low immediately after the A5 stop bit), status reads 0 for overrun, and busy is high for 80 cycles.
REQ-036 Set overrun, then write 12'h002 to ADDR_STAT: the next status read shows bit1=0. Issue the clear on the same edge as a new overrun: bit1 stays 1.
REQ-037 Assert rst asynchronously at cycle 17 of a frame: tx=1 and busy=0 immediately, before the next clk edge, with status 12'h001 after release.
REQ-038 Read addr=9'o100: sel=0 and data_out=0. Read ADDR_DATA after writing 12'hF7E: data_out=12'h07E.

Source files
------------

// File: rtl/simplez_uart_tx.sv
// simplez_uart_tx: memory-mapped 8N1 serial transmitter for the Simplez CPU, state updated on the falling clock edge.
// Define SIMPLEZ_UART_HOLD_EN to add a one-byte hold register so that frames can be sent back-to-back.
module simplez_uart_tx #(
  parameter int DATAW = 12,
  parameter int ADDRW = 9,
  parameter int BAUD_DIV = 104,
  parameter logic [ADDRW-1:0] ADDR_DATA = 9'o506,
  parameter logic [ADDRW-1:0] ADDR_STAT = 9'o507
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] addr,
  input  logic             wr,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             sel,
  output logic             tx,
  output logic             busy
);
  localparam int CW = $clog2(BAUD_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, last_byte;
  logic overrun, ready, wrap, wr_data, wr_stat, accept, ovr_set, unused_hi;
`ifdef SIMPLEZ_UART_HOLD_EN
  logic [7:0] hold;
  logic hold_full;
  assign ready = !hold_full;
`else
  assign ready = (state == IDLE);
`endif
  assign busy = (state != IDLE);
  assign wrap = (cnt == CW'(BAUD_DIV - 1));
  assign wr_data = wr && (addr == ADDR_DATA);
  assign wr_stat = wr && (addr == ADDR_STAT);
  assign accept = wr_data && ready;
  assign ovr_set = wr_data && !ready;
  assign sel = (addr == ADDR_DATA) || (addr == ADDR_STAT);
  assign data_out = (addr == ADDR_DATA) ? DATAW'(last_byte) :
                    (addr == ADDR_STAT) ? DATAW'({busy, overrun, ready}) : '0;
  assign unused_hi = ^data_in[DATAW-1:8];
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      last_byte <= '0;
      overrun <= 1'b0;
`ifdef SIMPLEZ_UART_HOLD_EN
      hold <= '0;
      hold_full <= 1'b0;
`endif
    end else begin
      // a new overrun outranks a clear on the same edge
      if (ovr_set) overrun <= 1'b1;
      else if (wr_stat && data_in[1]) overrun <= 1'b0;
      if (accept) last_byte <= data_in[7:0];
      cnt <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (accept) begin
          state <= START;
          shreg <= data_in[7:0];
          tx <= 1'b0;
        end
        START: if (wrap) begin
          state <= DATA;
          tx <= shreg[0];
          shreg <= shreg >> 1;
        end
        DATA: if (wrap) begin
          bit_cnt <= bit_cnt + 1'b1;
          state <= (bit_cnt == 3'd7) ? STOP : DATA;
          tx <= (bit_cnt == 3'd7) ? 1'b1 : shreg[0];
          shreg <= shreg >> 1;
        end
        STOP: if (wrap) begin
`ifdef SIMPLEZ_UART_HOLD_EN
          // pending byte (held, or arriving this edge) starts the next frame with no idle gap
          if (hold_full || accept) begin
            state <= START;
            tx <= 1'b0;
            shreg <= hold_full ? hold : data_in[7:0];
            hold_full <= 1'b0;
          end else state <= IDLE;
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
`ifdef SIMPLEZ_UART_HOLD_EN
      if (accept && state != IDLE && !(state == STOP && wrap)) begin
        hold <= data_in[7:0];
        hold_full <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_simplez_uart_tx.sv
// tb_simplez_uart_tx: directed vector bench for simplez_uart_tx with BAUD_DIV=4.
module tb_simplez_uart_tx;
  localparam int BD = 4;
  localparam logic [8:0] A_DATA = 9'o506, A_STAT = 9'o507, A_OTHER = 9'o100;
  logic clk, rst, wr, sel, tx, busy;
  logic [8:0] addr;
  logic [11:0] data_in, data_out;
  int total, passed;

  simplez_uart_tx #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .data_in(data_in),
    .data_out(data_out), .sel(sel), .tx(tx), .busy(busy)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  typedef struct {
    logic [8:0] addr;
    logic wr;
    logic [11:0] din;
    logic sel;
    logic [11:0] dout;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // expected {busy,tx} at sample k (k=1 is the first posedge after the start edge)
  function automatic logic [1:0] fexp(input int k, input logic [7:0] b);
    int seg;
    seg = (k - 1) / BD;
    if (k < 1 || k > 10 * BD) return 2'b01;
    if (seg == 0) return 2'b10;
    if (seg <= 8) return {1'b1, b[seg-1]};
    return 2'b11;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) @(posedge clk);
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic write(input logic [8:0] a, input logic [11:0] d);
    addr = a; wr = 1'b1; data_in = d;
    @(posedge clk);
    wr = 1'b0; addr = A_OTHER; data_in = '0;
  endtask

  initial begin
    int nk;
    logic [1:0] e;
    total = 0; passed = 0;
    rst = 1'b1; wr = 1'b0; addr = A_STAT; data_in = '0;
    #2;
    check("reset_state", {29'd0, busy, tx, sel}, {29'd0, 3'b011});
    check("reset_status", {20'd0, data_out}, 32'h001);
    @(posedge clk);
    rst = 1'b0;

    vecs[0] = '{A_OTHER, 1'b0, 12'h000, 1'b0, 12'h000};
    vecs[1] = '{A_STAT,  1'b0, 12'h000, 1'b1, 12'h001};
    vecs[2] = '{A_DATA,  1'b0, 12'h000, 1'b1, 12'h000};
    vecs[3] = '{A_OTHER, 1'b1, 12'hFFF, 1'b0, 12'h000};
    vecs[4] = '{A_STAT,  1'b1, 12'hFFF, 1'b1, 12'h001};
    vecs[5] = '{A_STAT,  1'b0, 12'h000, 1'b1, 12'h001};
    vecs[6] = '{9'o505,  1'b0, 12'h000, 1'b0, 12'h000};
    vecs[7] = '{9'o510,  1'b0, 12'h000, 1'b0, 12'h000};
    for (int i = 0; i < 8; i++) begin
      addr = vecs[i].addr; wr = vecs[i].wr; data_in = vecs[i].din;
      #1;
      check($sformatf("vec%0d_sel", i), {31'd0, sel}, {31'd0, vecs[i].sel});
      check($sformatf("vec%0d_dout", i), {20'd0, data_out}, {20'd0, vecs[i].dout});
      @(posedge clk);
    end
    wr = 1'b0; addr = A_OTHER; data_in = '0;

    write(A_DATA, 12'h055);
    for (int k = 1; k <= 10 * BD + 1; k++) begin
      check($sformatf("frame55_k%0d", k), {30'd0, busy, tx}, {30'd0, fexp(k, 8'h55)});
      @(posedge clk);
    end

`ifdef SIMPLEZ_UART_HOLD_EN
    nk = 20 * BD + 1;
`else
    nk = 10 * BD + 1;
`endif
    write(A_DATA, 12'h0A5);
    for (int k = 1; k <= nk; k++) begin
      e = (k <= 10 * BD) ? fexp(k, 8'hA5) : fexp(k - 10 * BD, 8'h3C);
`ifndef SIMPLEZ_UART_HOLD_EN
      if (k > 10 * BD) e = 2'b01;
`endif
      check($sformatf("pair_k%0d", k), {30'd0, busy, tx}, {30'd0, e});
      if (k == 5) begin addr = A_DATA; wr = 1'b1; data_in = 12'h03C; end
      if (k == 6) begin
        wr = 1'b0; addr = A_STAT; data_in = '0;
        #1;
`ifdef SIMPLEZ_UART_HOLD_EN
        check("pair_status", {20'd0, data_out}, 32'h004);
`else
        check("pair_status", {20'd0, data_out}, 32'h006);
`endif
      end
      if (k == 7) begin
        addr = A_DATA;
        #1;
`ifdef SIMPLEZ_UART_HOLD_EN
        check("pair_lastbyte", {20'd0, data_out}, 32'h03C);
`else
        check("pair_lastbyte", {20'd0, data_out}, 32'h0A5);
`endif
        addr = A_OTHER;
      end
      @(posedge clk);
    end
    wait_idle();

    addr = A_DATA; wr = 1'b1; data_in = 12'h011;
    repeat (3) @(posedge clk);
    wr = 1'b0; addr = A_STAT; data_in = '0;
    #1;
    check("ovr_set", {20'd0, data_out & 12'h002}, 32'h002);
    write(A_STAT, 12'h002);
    addr = A_STAT;
    #1;
    check("ovr_clear", {20'd0, data_out & 12'h002}, 32'h000);
    write(A_DATA, 12'h022);
    addr = A_STAT;
    #1;
    check("ovr_reset_again", {20'd0, data_out & 12'h002}, 32'h002);
    wait_idle();
    write(A_STAT, 12'h002);

    write(A_DATA, 12'h000);
    for (int k = 1; k < 17; k++) @(posedge clk);
    check("pre_rst_k17", {30'd0, busy, tx}, {30'd0, fexp(17, 8'h00)});
    #2 rst = 1'b1;
    #1;
    check("async_rst", {30'd0, busy, tx}, 32'b01);
    @(posedge clk);
    rst = 1'b0;
    addr = A_STAT;
    #1;
    check("post_rst_status", {20'd0, data_out}, 32'h001);
    write(A_DATA, 12'hF7E);
    addr = A_DATA;
    #1;
    check("first_write_start", {30'd0, busy, tx}, 32'b10);
    check("data_readback", {20'd0, data_out}, 32'h07E);
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
